// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file dump reader: register file geometry and
// the dump FSM state encoding.
package regfile_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned REG_DATA_W = 32;
   localparam int unsigned NUM_REGS   = 32;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      SEND,
      SUM,
      FIN
   } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Debug reader that walks registers FIRST_REG..LAST_REG through a dedicated read port and
// streams them on a valid/ready interface. Define REGFILE_DUMP_CHECKSUM_EN to append an XOR beat.
module regfile_dump
   import regfile_pkg::*;
#(
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = 31
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   output logic [REG_ADDR_W-1:0] rd_addr,
   input  logic [REG_DATA_W-1:0] rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [REG_DATA_W-1:0] out_data,
   output logic [REG_ADDR_W-1:0] out_idx,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);

   localparam logic [REG_ADDR_W-1:0] FirstIdx = REG_ADDR_W'(FIRST_REG);
   localparam logic [REG_ADDR_W-1:0] LastIdx  = REG_ADDR_W'(LAST_REG);

   if (LAST_REG < FIRST_REG || LAST_REG >= NUM_REGS) begin : gen_bad_range
      $error("regfile_dump: register range must satisfy FIRST_REG <= LAST_REG < 32");
   end

   dump_state_t           state_q, state_d;
   logic [REG_ADDR_W-1:0] idx_q, idx_d;
   logic [REG_DATA_W-1:0] data_q, data_d;
   logic [REG_ADDR_W-1:0] oidx_q, oidx_d;
   logic                  last_q, last_d;
   logic                  at_last;

`ifdef REGFILE_DUMP_CHECKSUM_EN
   logic [REG_DATA_W-1:0] acc_q, acc_d;
`endif

   assign at_last = (idx_q == LastIdx);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      oidx_d  = oidx_q;
      last_d  = last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_d   = acc_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = READ;
               idx_d   = FirstIdx;
`ifdef REGFILE_DUMP_CHECKSUM_EN
               acc_d   = '0;
`endif
            end
         end
         READ: begin
            state_d = SEND;
            data_d  = rd_data;
            oidx_d  = idx_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            last_d  = 1'b0;
            acc_d   = acc_q ^ rd_data;
`else
            last_d  = at_last;
`endif
         end
         SEND: begin
            if (out_ready) begin
               if (at_last) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                  // Checksum beat reuses the output register; acc_q already holds the last read.
                  state_d = SUM;
                  data_d  = acc_q;
                  oidx_d  = '0;
                  last_d  = 1'b1;
`else
                  state_d = FIN;
`endif
               end else begin
                  state_d = READ;
                  idx_d   = idx_q + REG_ADDR_W'(1);
               end
            end
         end
`ifdef REGFILE_DUMP_CHECKSUM_EN
         SUM: begin
            if (out_ready) begin
               state_d = FIN;
            end
         end
`endif
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort beats every other transition, including an accept in the same cycle.
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
`ifdef REGFILE_DUMP_CHECKSUM_EN
         acc_d   = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         data_q  <= '0;
         oidx_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         oidx_q  <= oidx_d;
         last_q  <= last_d;
      end
   end

`ifdef REGFILE_DUMP_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`endif

   assign rd_addr   = (state_q == IDLE) ? '0 : idx_q;
   assign out_valid = (state_q == SEND) || (state_q == SUM);
   assign out_data  = data_q;
   assign out_idx   = oidx_q;
   assign out_last  = last_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == FIN);

endmodule
